usb_tx_arbiter: RTL and testbench
=================================

// Module: usb_tx_arbiter
// PURPOSE
//  Shares the single transmit interface of the USB packet encoder (handshake + DATAx path) among EP_NUM
//  endpoint requesters (EP0 control, bulk EPs). Grants one requester per packet (round-robin), muxes its
//  handshake/data stream onto the encoder, holds the grant until the packet completes, then inserts a gap
//  so the encoder can finish its CRC bytes and return to idle before the next packet.
// PARAMETERS
//  EP_NUM      2  number of requesters, 1..4; index i occupies bit i / slice [i*W +: W] of flattened buses
//  GAP_CYCLES  4  idle cycles after each packet before re-arbitration, >=1 (covers encoder CRC1/CRC2)
// PORTS
//  clk                 in   1         system clock
//  rst_n               in   1         reset, asynchronous assert, active-low
//  req_hsk_i           in   EP_NUM    level: requester wants to send a handshake
//  req_hsk_type_i      in   2*EP_NUM  00 ACK, 10 NAK, 11 STALL, 01 NYET
//  req_data_i          in   EP_NUM    level: requester wants to send a DATAx packet
//  req_dtype_i         in   2*EP_NUM  DATA0/1/2/MDATA PID bits
//  req_tvalid_i        in   EP_NUM    data beat valid
//  req_tlast_i         in   EP_NUM    last data beat (with !tvalid at start = zero-length packet)
//  req_tdata_i         in   8*EP_NUM  data byte
//  req_tready_o        out  EP_NUM    data beat accepted (granted requester only)
//  gnt_o               out  EP_NUM    one-hot grant, registered
//  done_o              out  EP_NUM    1-cycle pulse: granted packet finished; requester drops its request
//  err_o               out  1         1-cycle pulse: granted stream dropped tvalid mid-packet
//  tx_trn_send_hsk     out  1         to encoder
//  tx_trn_hsk_type     out  2         to encoder
//  tx_trn_hsk_sent     in   1         from encoder
//  tx_trn_data_start   out  1         to encoder, 1-cycle pulse
//  tx_trn_data_type    out  2         to encoder
//  tx_trn_data         out  8         to encoder (muxed from granted requester)
//  tx_trn_data_valid   out  1         to encoder (muxed)
//  tx_trn_data_last    out  1         to encoder (muxed)
//  tx_trn_data_ready   in   1         from encoder
// BEHAVIOUR
//  - Reset (rst_n=0, any time incl. mid-packet): state IDLE, all outputs 0, gap counter 0, last-grant pointer
//    = EP_NUM-1 (EP0 wins first arbitration). Encoder reset is handled by its own reset.
//  - FSM IDLE -> HSK | DSTART -> DATA -> GAP -> IDLE; HSK -> GAP.
//  - IDLE: requester i active if req_hsk_i[i]|req_data_i[i]. Winner = first active index after last-grant,
//    wrapping modulo EP_NUM. Register gnt_o, latch hsk_type/dtype, update last-grant. Winner's req_hsk has
//    priority over its req_data -> HSK; else DSTART. No active request -> stay IDLE.
//  - HSK: tx_trn_send_hsk=1 with latched type. On tx_trn_hsk_sent=1: send_hsk low next cycle,
//    done_o[g] pulse, -> GAP.
//  - DSTART (1 cycle): tx_trn_data_start=1, data_type latched, valid/last/data muxed from granted requester.
//    If granted last=1 & valid=0 (zero-length): done_o[g] pulse, -> GAP; else -> DATA.
//  - DATA: tx_trn_data* = granted requester; req_tready_o[g] = tx_trn_data_ready; others 0.
//    valid&ready&last -> done_o[g], -> GAP. valid=0 (encoder closes packet) -> err_o & done_o[g] pulse, -> GAP.
//  - GAP: all encoder strobes 0, gnt_o cleared on entry; count GAP_CYCLES then IDLE. Requests ignored in GAP.
//  - Data mux is combinational (zero added latency); grant to send_hsk/data_start latency = 1 cycle.
//  - Requests asserted during a packet wait; simultaneous requests resolved by rotation only.
// CONFIGURATION
//  USB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins (EP0 always first); last-grant pointer unused.
//  Undefined (default): round-robin as above.
// TESTING
//  1 EP0 req_hsk type 10 alone -> send_hsk=1 with type 10 until hsk_sent; done_o=01; next grant >=4 cycles later.
//  2 EP0 & EP1 req_data held continuously, 3-byte packets -> grants alternate 01,10,01; data_start once each.
//  3 EP1 req_data with tlast=1, tvalid=0 -> data_start, data_last=1, valid=0; done_o=10 on DSTART exit; no DATA.
//  4 EP0 data A5,5A then tvalid drops before last -> err_o pulse, done_o=01, FSM GAP->IDLE.
//  5 rst_n low mid-DATA -> all outputs 0 immediately; after release EP0 wins with both requesting.
//  6 USB_ARB_FIXED_PRIO_EN, EP0/EP1 both requesting -> EP0 granted every packet, EP1 starved.

Source files
------------

// File: rtl/usb_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : usb_tx_arbiter
// Brief    : Shares the USB packet-encoder TX port (handshake + DATAx) among
//            EP_NUM endpoint requesters, one packet per grant, with a fixed
//            idle gap after each packet. Round-robin by default; define
//            USB_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_arbiter #(
  parameter int EP_NUM     = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [EP_NUM-1:0]     req_hsk_i,
  input  logic [2*EP_NUM-1:0]   req_hsk_type_i,
  input  logic [EP_NUM-1:0]     req_data_i,
  input  logic [2*EP_NUM-1:0]   req_dtype_i,
  input  logic [EP_NUM-1:0]     req_tvalid_i,
  input  logic [EP_NUM-1:0]     req_tlast_i,
  input  logic [8*EP_NUM-1:0]   req_tdata_i,
  output logic [EP_NUM-1:0]     req_tready_o,
  output logic [EP_NUM-1:0]     gnt_o,
  output logic [EP_NUM-1:0]     done_o,
  output logic                  err_o,
  output logic                  tx_trn_send_hsk,
  output logic [1:0]            tx_trn_hsk_type,
  input  logic                  tx_trn_hsk_sent,
  output logic                  tx_trn_data_start,
  output logic [1:0]            tx_trn_data_type,
  output logic [7:0]            tx_trn_data,
  output logic                  tx_trn_data_valid,
  output logic                  tx_trn_data_last,
  input  logic                  tx_trn_data_ready
);

  localparam int c_IDX_W = (EP_NUM > 1) ? $clog2(EP_NUM) : 1;
  localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HSK    = 3'd1,
    ST_DSTART = 3'd2,
    ST_DATA   = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  state_t               r_state;
  logic [EP_NUM-1:0]    r_gnt;
  logic [EP_NUM-1:0]    r_done;
  logic [1:0]           r_hsk_type;
  logic [1:0]           r_dtype;
  logic                 r_send_hsk;
  logic                 r_data_start;
  logic                 r_err;
  logic [c_GAP_W-1:0]   r_gap_cnt;

  logic [EP_NUM-1:0]    w_active;
  logic                 w_any;
  logic [EP_NUM-1:0]    w_win_oh;
  logic                 w_win_hsk;
  logic [1:0]           w_win_ht;
  logic [1:0]           w_win_dt;
  logic                 w_g_valid;
  logic                 w_g_last;
  logic [7:0]           w_g_data;
  logic                 w_stream;

  assign w_active = req_hsk_i | req_data_i;
  assign w_any    = |w_active;

`ifdef USB_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win_oh = '0;
    for (int i = EP_NUM - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end
`else
  logic [c_IDX_W-1:0] r_last;
  logic [c_IDX_W-1:0] w_win_idx;

  // Lowest active index above the last grant wins; if none, wrap to the lowest active index.
  always_comb begin
    w_win_oh  = '0;
    w_win_idx = '0;
    for (int i = EP_NUM - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_idx   = c_IDX_W'(i);
      end
    end
    for (int i = EP_NUM - 1; i >= 0; i--) begin
      if (w_active[i] && (i > int'(r_last))) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_idx   = c_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_IDX_W'(EP_NUM - 1);
    end else if (r_state == ST_IDLE && w_any) begin
      r_last <= w_win_idx;
    end
  end
`endif

  always_comb begin
    w_win_hsk = 1'b0;
    w_win_ht  = '0;
    w_win_dt  = '0;
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < EP_NUM; i++) begin
      if (w_win_oh[i]) begin
        w_win_hsk = req_hsk_i[i];
        w_win_ht  = req_hsk_type_i[2*i +: 2];
        w_win_dt  = req_dtype_i[2*i +: 2];
      end
      if (r_gnt[i]) begin
        w_g_valid = req_tvalid_i[i];
        w_g_last  = req_tlast_i[i];
        w_g_data  = req_tdata_i[8*i +: 8];
      end
    end
  end

  // Stream path is combinational so the encoder sees the granted beat with no added latency.
  assign w_stream          = (r_state == ST_DSTART) || (r_state == ST_DATA);
  assign tx_trn_data       = w_stream ? w_g_data : 8'h00;
  assign tx_trn_data_valid = w_stream & w_g_valid;
  assign tx_trn_data_last  = w_stream & w_g_last;
  assign req_tready_o      = (r_state == ST_DATA) ? (r_gnt & {EP_NUM{tx_trn_data_ready}}) : '0;

  assign gnt_o             = r_gnt;
  assign done_o            = r_done;
  assign err_o             = r_err;
  assign tx_trn_send_hsk   = r_send_hsk;
  assign tx_trn_hsk_type   = r_hsk_type;
  assign tx_trn_data_start = r_data_start;
  assign tx_trn_data_type  = r_dtype;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_done       <= '0;
      r_hsk_type   <= '0;
      r_dtype      <= '0;
      r_send_hsk   <= 1'b0;
      r_data_start <= 1'b0;
      r_err        <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_win_oh;
            r_hsk_type <= w_win_ht;
            r_dtype    <= w_win_dt;
            if (w_win_hsk) begin
              r_send_hsk <= 1'b1;
              r_state    <= ST_HSK;
            end else begin
              r_data_start <= 1'b1;
              r_state      <= ST_DSTART;
            end
          end
        end
        ST_HSK: begin
          if (tx_trn_hsk_sent) begin
            r_send_hsk <= 1'b0;
            r_done     <= r_gnt;
            r_gnt      <= '0;
            r_state    <= ST_GAP;
          end
        end
        ST_DSTART: begin
          r_data_start <= 1'b0;
          if (w_g_last && !w_g_valid) begin
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!w_g_valid) begin
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_state <= ST_GAP;
          end else if (tx_trn_data_ready && w_g_last) begin
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for usb_tx_arbiter: directed scenarios and randomized packets checked
// against a packet-level model of grant order, encoder stream and gap timing.
module tb_usb_tx_arbiter;
  localparam int EP  = 2;
  localparam int GAP = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [EP-1:0]    req_hsk, req_data, req_tvalid, req_tlast, req_tready, gnt, done;
  logic [2*EP-1:0]  req_hsk_type, req_dtype;
  logic [8*EP-1:0]  req_tdata;
  logic             err, send_hsk, hsk_sent, data_start, data_valid, data_last, data_ready;
  logic [1:0]       hsk_type, data_type;
  logic [7:0]       data;

  int               n_chk = 0;
  int               n_fail = 0;
  int               last_gnt = EP - 1;
  int               plen [EP];
  int               drop_at [EP];
  int               bidx [EP];
  logic [7:0]       pay [EP][8];

  always #5 clk = ~clk;

  usb_tx_arbiter #(.EP_NUM(EP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_hsk_i(req_hsk), .req_hsk_type_i(req_hsk_type),
    .req_data_i(req_data), .req_dtype_i(req_dtype),
    .req_tvalid_i(req_tvalid), .req_tlast_i(req_tlast), .req_tdata_i(req_tdata),
    .req_tready_o(req_tready), .gnt_o(gnt), .done_o(done), .err_o(err),
    .tx_trn_send_hsk(send_hsk), .tx_trn_hsk_type(hsk_type), .tx_trn_hsk_sent(hsk_sent),
    .tx_trn_data_start(data_start), .tx_trn_data_type(data_type), .tx_trn_data(data),
    .tx_trn_data_valid(data_valid), .tx_trn_data_last(data_last), .tx_trn_data_ready(data_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  `define CHK(T, O, E) chk(T, 32'(O), 32'(E))

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_chk++;
      if ($onehot0(gnt) !== 1'b1) begin
        n_fail++;
        $error("FAIL mon_gnt_onehot: observed %0b expected one-hot or zero", gnt);
      end
      n_chk++;
      if ($onehot0(done) !== 1'b1) begin
        n_fail++;
        $error("FAIL mon_done_onehot: observed %0b expected one-hot or zero", done);
      end
      n_chk++;
      if ((err & (done == '0)) !== 1'b0) begin
        n_fail++;
        $error("FAIL mon_err_done: observed err=%0b done=%0b expected done with err", err, done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    `CHK({tag, "_gnt"}, gnt, 0);
    `CHK({tag, "_done"}, done, 0);
    `CHK({tag, "_err"}, err, 0);
    `CHK({tag, "_tready"}, req_tready, 0);
    `CHK({tag, "_send_hsk"}, send_hsk, 0);
    `CHK({tag, "_hsk_type"}, hsk_type, 0);
    `CHK({tag, "_data_start"}, data_start, 0);
    `CHK({tag, "_data_type"}, data_type, 0);
    `CHK({tag, "_data"}, data, 0);
    `CHK({tag, "_valid"}, data_valid, 0);
    `CHK({tag, "_last"}, data_last, 0);
  endtask

  // Arbitration rule: nearest active requester after the previous grant, modulo EP.
  function automatic int pick();
    int r;
    r = -1;
`ifdef USB_ARB_FIXED_PRIO_EN
    for (int k = EP - 1; k >= 0; k--)
      if (req_hsk[k] | req_data[k]) r = k;
`else
    for (int s = EP; s >= 1; s--)
      if (req_hsk[(last_gnt + s) % EP] | req_data[(last_gnt + s) % EP]) r = (last_gnt + s) % EP;
`endif
    return r;
  endfunction

  // Granted requester w follows its packet plan; every other requester drives noise.
  task automatic drive(input int w);
    for (int k = 0; k < EP; k++) begin
      if (k == w) begin
        if (bidx[k] == drop_at[k]) begin
          req_tvalid[k] = 1'b0; req_tlast[k] = 1'b0; req_tdata[k*8 +: 8] = 8'($urandom);
        end else if (plen[k] == 0) begin
          req_tvalid[k] = 1'b0; req_tlast[k] = 1'b1; req_tdata[k*8 +: 8] = 8'($urandom);
        end else begin
          req_tvalid[k] = 1'b1;
          req_tlast[k]  = (bidx[k] == plen[k] - 1);
          req_tdata[k*8 +: 8] = pay[k][bidx[k]];
        end
      end else begin
        req_tvalid[k] = 1'($urandom); req_tlast[k] = 1'($urandom); req_tdata[k*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  // Runs one packet from the arbitration cycle through the full idle gap.
  task automatic packet();
    int w, d, cyc;
    logic [EP-1:0] oh, exp_tr;
    logic [1:0] ht, dt;
    bit is_hsk, fin, err_exp, rdy;
    w = pick();
    if (w < 0) begin
      `CHK("no_request", 1, 0);
      return;
    end
    oh = '0; oh[w] = 1'b1;
    is_hsk = req_hsk[w];
    ht = req_hsk_type[2*w +: 2];
    dt = req_dtype[2*w +: 2];
    last_gnt = w;
    bidx[w] = 0;
    err_exp = 1'b0;
    tick();
    req_hsk_type = (2*EP)'($urandom);
    req_dtype    = (2*EP)'($urandom);
    if (is_hsk) begin
      d = $urandom_range(0, 3);
      for (int c = 0; c <= d; c++) begin
        if (c > 0) tick();
        drive(w);
        hsk_sent = (c == d);
        data_ready = 1'($urandom);
        #1;
        `CHK("hsk_gnt", gnt, oh);
        `CHK("hsk_send", send_hsk, 1);
        `CHK("hsk_type", hsk_type, ht);
        `CHK("hsk_no_start", data_start, 0);
        `CHK("hsk_no_valid", data_valid, 0);
        `CHK("hsk_no_done", done, 0);
      end
    end else begin
      cyc = 0; fin = 1'b0;
      while (!fin) begin
        if (cyc > 0) tick();
        drive(w);
        rdy = (cyc > 12) ? 1'b1 : 1'($urandom);
        data_ready = rdy;
        #1;
        exp_tr = (cyc > 0 && rdy) ? oh : '0;
        `CHK("dat_gnt", gnt, oh);
        `CHK("dat_start", data_start, (cyc == 0));
        `CHK("dat_type", data_type, dt);
        `CHK("dat_no_hsk", send_hsk, 0);
        `CHK("dat_valid", data_valid, req_tvalid[w]);
        `CHK("dat_last", data_last, req_tlast[w]);
        `CHK("dat_byte", data, req_tdata[8*w +: 8]);
        `CHK("dat_tready", req_tready, exp_tr);
        `CHK("dat_no_done", done, 0);
        if (cyc == 0) begin
          fin = req_tlast[w] & ~req_tvalid[w];
        end else if (!req_tvalid[w]) begin
          fin = 1'b1; err_exp = 1'b1;
        end else if (rdy) begin
          if (req_tlast[w]) fin = 1'b1;
          else bidx[w]++;
        end
        cyc++;
      end
    end
    tick();
    hsk_sent = 1'b0;
    drive(-1);
    #1;
    `CHK("end_done", done, oh);
    `CHK("end_err", err, err_exp);
    `CHK("end_gnt", gnt, 0);
    `CHK("end_send", send_hsk, 0);
    `CHK("end_start", data_start, 0);
    `CHK("end_valid", data_valid, 0);
    `CHK("end_tready", req_tready, 0);
    for (int g = 0; g < GAP; g++) begin
      tick();
      #1;
      `CHK("gap_gnt", gnt, 0);
      `CHK("gap_done", done, 0);
      `CHK("gap_err", err, 0);
      `CHK("gap_send", send_hsk, 0);
      `CHK("gap_valid", data_valid, 0);
    end
  endtask

  task automatic set_plan(input int k, input int len, input int drop);
    plen[k] = len;
    drop_at[k] = drop;
    for (int j = 0; j < 8; j++) pay[k][j] = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_hsk = '0; req_data = '0; req_hsk_type = '0; req_dtype = '0;
    req_tvalid = '0; req_tlast = '0; req_tdata = '0;
    hsk_sent = 1'b0; data_ready = 1'b0;
    for (int k = 0; k < EP; k++) begin set_plan(k, 0, -1); bidx[k] = 0; end
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // EP0 NAK handshake alone
    req_hsk = 2'b01; req_hsk_type = 4'b0010;
    packet();
    req_hsk = '0;

    // EP1 zero-length data packet
    req_data = 2'b10; req_dtype = 4'b0100; set_plan(1, 0, -1);
    packet();

    // EP0 and EP1 both streaming 3-byte packets continuously
    req_data = 2'b11;
    for (int p = 0; p < 3; p++) begin
      set_plan(0, 3, -1); set_plan(1, 3, -1);
      packet();
    end

    // EP0 drops tvalid after A5,5A
    req_data = 2'b01; set_plan(0, 4, 2); pay[0][0] = 8'hA5; pay[0][1] = 8'h5A;
    packet();

    // Randomized mix of handshakes, data, zero-length and aborted packets
    for (int n = 0; n < 30; n++) begin
      do begin
        req_hsk = EP'($urandom); req_data = EP'($urandom);
      end while ((req_hsk | req_data) == '0);
      req_hsk_type = (2*EP)'($urandom); req_dtype = (2*EP)'($urandom);
      for (int k = 0; k < EP; k++) begin
        set_plan(k, $urandom_range(0, 4), -1);
        if (plen[k] > 0 && $urandom_range(0, 4) == 0) drop_at[k] = $urandom_range(0, plen[k] - 1);
      end
      packet();
    end

    // Asynchronous reset in the middle of an EP1 data packet
    req_hsk = '0; req_data = 2'b10; set_plan(1, 4, -1); bidx[1] = 0;
    tick();
    drive(1); data_ready = 1'b1; #1;
    `CHK("mid_gnt", gnt, 2'b10);
    tick();
    drive(1); #1;
    `CHK("mid_tready", req_tready, 2'b10);
    `CHK("mid_valid", data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    chk_zero("rst_held");
    rst_n = 1'b1;
    last_gnt = EP - 1;
    req_hsk = 2'b11; req_data = '0; req_hsk_type = 4'b1100;
    packet();
    req_hsk = '0; req_data = 2'b11;
    set_plan(0, 2, -1); set_plan(1, 1, -1);
    packet();
    packet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  `undef CHK
endmodule
`default_nettype wire
